aes_inv_round_ctrl: RTL and testbench

//  Sequencing FSM for the AES decryption datapath.
//  - Controls the registered stages InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
//  - Issues one-hot stage strobes, the feedback mux select and the round-key index, in FIPS-197 inverse-cipher order.
//  - Takes blocks through a start handshake and reports completion through a done handshake.

---
 rtl/aes_inv_round_ctrl.sv | 105 ++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_ctrl.sv
// Sequencing FSM for the AES inverse-cipher datapath: stage strobes, input mux select and round-key index.
// Optional abort port pair is compiled in when AES_INV_ABORT_EN is defined.
module aes_inv_round_ctrl #(
  parameter int NR        = 10,
  parameter int STAGE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ready,
  input  logic       start_valid,
  output logic       start_ready,
  output logic       done_valid,
  input  logic       done_ready,
  output logic       sel_init,
  output logic       en_isr,
  output logic       en_isb,
  output logic       en_ark,
  output logic       en_imc,
  output logic [3:0] rk_idx,
  output logic       busy
`ifdef AES_INV_ABORT_EN
  ,
  input  logic       abort,
  output logic       aborted
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARK0, S_ISR, S_ISB, S_ARK, S_IMC, S_DONE
  } state_t;

  localparam int            CW       = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
  localparam logic [CW-1:0] LAST     = CW'(STAGE_LAT - 1);
  localparam logic [3:0]    RND_INIT = 4'(NR);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_rnd;
  logic          w_last, w_stage, w_accept, w_abort;

  assign w_last      = (r_cnt == LAST);
  assign w_stage     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign start_ready = (r_state == S_IDLE) && key_ready;
  assign w_accept    = start_valid && start_ready;
  assign rk_idx      = r_rnd;

`ifdef AES_INV_ABORT_EN
  logic r_aborted;
  assign w_abort = abort && (r_state != S_IDLE);
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // State, per-state wait counter and round register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rnd   <= RND_INIT;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || !w_stage) r_cnt <= '0;
      else                               r_cnt <= r_cnt + CW'(1);
      if (w_accept)
        r_rnd <= RND_INIT;
      else if (!w_abort && w_last && (r_state == S_ARK0 || r_state == S_IMC))
        r_rnd <= r_rnd - 4'd1;
    end
  end

`ifdef AES_INV_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_aborted <= 1'b0;
    else     r_aborted <= w_abort;
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)   w_next = S_ARK0;
      S_ARK0: if (w_last)     w_next = S_ISR;
      S_ISR:  if (w_last)     w_next = S_ISB;
      S_ISB:  if (w_last)     w_next = S_ARK;
      // Final round skips InvMixColumns; rnd==0 here can never wrap
      S_ARK:  if (w_last)     w_next = (r_rnd == 4'd0) ? S_DONE : S_IMC;
      S_IMC:  if (w_last)     w_next = S_ISR;
      S_DONE: if (done_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_comb begin
    sel_init   = (r_state == S_ARK0);
    en_isr     = (r_state == S_ISR) && (r_cnt == '0);
    en_isb     = (r_state == S_ISB) && (r_cnt == '0);
    en_ark     = (r_state == S_ARK0 || r_state == S_ARK) && (r_cnt == '0);
    en_imc     = (r_state == S_IMC) && (r_cnt == '0);
    done_valid = (r_state == S_DONE);
    busy       = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: two instances (NR=10/LAT=1 and NR=14/LAT=3) against a stage-list model.
module tb_aes_inv_round_ctrl;
  logic clk = 1'b0, rst = 1'b1, key_ready = 1'b1;
  logic sv_a = 1'b0, dr_a = 1'b0, sv_b = 1'b0, dr_b = 1'b0;
  logic sr_a, dv_a, sel_a, isr_a, isb_a, ark_a, imc_a, busy_a;
  logic sr_b, dv_b, sel_b, isr_b, isb_b, ark_b, imc_b, busy_b;
  logic [3:0] rk_a, rk_b;
`ifdef AES_INV_ABORT_EN
  logic abort_a = 1'b0, abort_b = 1'b0, aborted_a, aborted_b;
`endif
  int checks = 0, errors = 0;
  typedef logic [10:0] vec_t;   // {sel, isr, isb, ark, imc, rk[3:0], done_valid, busy}
  vec_t exp_q[$];

  always #5 clk = ~clk;

  aes_inv_round_ctrl #(.NR(10), .STAGE_LAT(1)) u_a (
    .clk(clk), .rst(rst), .key_ready(key_ready), .start_valid(sv_a), .start_ready(sr_a),
    .done_valid(dv_a), .done_ready(dr_a), .sel_init(sel_a), .en_isr(isr_a), .en_isb(isb_a),
    .en_ark(ark_a), .en_imc(imc_a), .rk_idx(rk_a), .busy(busy_a)
`ifdef AES_INV_ABORT_EN
    , .abort(abort_a), .aborted(aborted_a)
`endif
  );

  aes_inv_round_ctrl #(.NR(14), .STAGE_LAT(3)) u_b (
    .clk(clk), .rst(rst), .key_ready(key_ready), .start_valid(sv_b), .start_ready(sr_b),
    .done_valid(dv_b), .done_ready(dr_b), .sel_init(sel_b), .en_isr(isr_b), .en_isb(isb_b),
    .en_ark(ark_b), .en_imc(imc_b), .rk_idx(rk_b), .busy(busy_b)
`ifdef AES_INV_ABORT_EN
    , .abort(abort_b), .aborted(aborted_b)
`endif
  );

  function automatic vec_t obs(input int w);
    return (w == 0) ? {sel_a, isr_a, isb_a, ark_a, imc_a, rk_a, dv_a, busy_a}
                    : {sel_b, isr_b, isb_b, ark_b, imc_b, rk_b, dv_b, busy_b};
  endfunction

  function automatic logic sr(input int w);
    return (w == 0) ? sr_a : sr_b;
  endfunction

  function automatic vec_t mk(input logic sel, input logic [3:0] en, input int rk,
                              input logic dv, input logic bz);
    return {sel, en, 4'(rk), dv, bz};
  endfunction

  task automatic set_sv(input int w, input logic v);
    if (w == 0) sv_a = v; else sv_b = v;
  endtask

  task automatic set_dr(input int w, input logic v);
    if (w == 0) dr_a = v; else dr_b = v;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Expected per-cycle outputs from the inverse-cipher stage order
  task automatic push_stage(input logic [3:0] en, input logic sel, input int rk, input int l);
    for (int k = 0; k < l; k++) exp_q.push_back(mk(sel, (k == 0) ? en : 4'b0, rk, 1'b0, 1'b1));
  endtask

  task automatic build(input int nr, input int l);
    exp_q.delete();
    push_stage(4'b0010, 1'b1, nr, l);
    for (int r = nr - 1; r >= 0; r--) begin
      push_stage(4'b1000, 1'b0, r, l);
      push_stage(4'b0100, 1'b0, r, l);
      push_stage(4'b0010, 1'b0, r, l);
      if (r > 0) push_stage(4'b0001, 1'b0, r, l);
    end
  endtask

  // Starts from IDLE at #1 after an edge; returns in the first DONE cycle
  task automatic start_and_run(input int w, input int nr, input int l, input bit noise);
    build(nr, l);
    set_sv(w, 1'b1); key_ready = 1'b1; #1;
    checks++;
    if (sr(w) !== 1'b1) begin errors++; $display("FAIL start_ready_idle got %b exp 1", sr(w)); end
    tick;
    set_sv(w, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      if (noise) begin
        key_ready = 1'($urandom_range(0, 1));
        set_dr(w, 1'($urandom_range(0, 1)));
        #1;
      end
      checks++;
      if (obs(w) !== exp_q[c] || sr(w) !== 1'b0) begin
        errors++;
        $display("FAIL stage_cycle%0d dut%0d got %h sr %b exp %h sr 0", c + 1, w, obs(w), sr(w), exp_q[c]);
      end
      tick;
    end
    set_dr(w, 1'b0); key_ready = 1'b1; #1;
    checks++;
    if (obs(w) !== mk(1'b0, 4'b0, 0, 1'b1, 1'b1)) begin
      errors++; $display("FAIL done_entry dut%0d got %h exp %h", w, obs(w), mk(1'b0, 4'b0, 0, 1'b1, 1'b1));
    end
  endtask

  task automatic finish_done(input int w, input int hold, input bit b2b);
    for (int h = 0; h < hold; h++) begin
      tick;
      checks++;
      if (obs(w) !== mk(1'b0, 4'b0, 0, 1'b1, 1'b1) || sr(w) !== 1'b0) begin
        errors++; $display("FAIL done_hold%0d dut%0d got %h sr %b", h, w, obs(w), sr(w));
      end
    end
    set_dr(w, 1'b1);
    if (b2b) set_sv(w, 1'b1);
    tick;
    set_dr(w, 1'b0);
    checks++;
    if (obs(w) !== mk(1'b0, 4'b0, 0, 1'b0, 1'b0) || sr(w) !== 1'b1) begin
      errors++; $display("FAIL done_release dut%0d got %h sr %b exp idle", w, obs(w), sr(w));
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; key_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs(0) !== mk(1'b0, 4'b0, 10, 1'b0, 1'b0) || sr(0) !== 1'b1) begin
      errors++; $display("FAIL reset_a got %h sr %b exp %h sr 1", obs(0), sr(0), mk(1'b0, 4'b0, 10, 1'b0, 1'b0));
    end
    checks++;
    if (obs(1) !== mk(1'b0, 4'b0, 14, 1'b0, 1'b0) || sr(1) !== 1'b1) begin
      errors++; $display("FAIL reset_b got %h sr %b exp %h sr 1", obs(1), sr(1), mk(1'b0, 4'b0, 14, 1'b0, 1'b0));
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_no_key;
    key_ready = 1'b0; sv_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (sr_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++; $display("FAIL no_key%0d sr %b busy %b exp 0 0", i, sr_a, busy_a);
      end
      tick;
    end
    sv_a = 1'b0; key_ready = 1'b1;
    tick;
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL no_key_after busy %b exp 0", busy_a); end
  endtask

  task automatic test_single;
    start_and_run(0, 10, 1, 1'b0);
    finish_done(0, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick;
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_gap busy %b exp 0", busy_a); end
      end
      start_and_run(0, 10, 1, 1'b1);
      finish_done(0, $urandom_range(0, 5), 1'b0);
    end
  endtask

  task automatic test_long;
    start_and_run(1, 14, 3, 1'b1);
    finish_done(1, 2, 1'b0);
  endtask

  task automatic test_back_to_back;
    start_and_run(0, 10, 1, 1'b0);
    finish_done(0, 7, 1'b1);
    start_and_run(0, 10, 1, 1'b0);
    finish_done(0, 0, 1'b0);
  endtask

  task automatic test_rst_mid;
    build(10, 1);
    sv_a = 1'b1; tick; sv_a = 1'b0;
    repeat (16) tick;
    checks++;
    if (obs(0) !== exp_q[16]) begin errors++; $display("FAIL pre_rst got %h exp %h", obs(0), exp_q[16]); end
    rst = 1'b1; #1;
    checks++;
    if (obs(0) !== mk(1'b0, 4'b0, 10, 1'b0, 1'b0) || sr_a !== 1'b1) begin
      errors++; $display("FAIL rst_mid got %h sr %b exp %h", obs(0), sr_a, mk(1'b0, 4'b0, 10, 1'b0, 1'b0));
    end
    tick; rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick;
      checks++;
      if (dv_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++; $display("FAIL rst_discard%0d dv %b busy %b exp 0 0", i, dv_a, busy_a);
      end
    end
  endtask

`ifdef AES_INV_ABORT_EN
  task automatic test_abort;
    sv_a = 1'b1; tick; sv_a = 1'b0;
    repeat (16) tick;
    abort_a = 1'b1; tick; abort_a = 1'b0;
    checks++;
    if (aborted_a !== 1'b1 || {sel_a, isr_a, isb_a, ark_a, imc_a, dv_a, busy_a} !== 7'b0) begin
      errors++; $display("FAIL abort_pulse aborted %b outs %h exp 1 idle", aborted_a, obs(0));
    end
    tick;
    checks++;
    if (aborted_a !== 1'b0) begin errors++; $display("FAIL abort_width aborted %b exp 0", aborted_a); end
    for (int i = 0; i < 30; i++) begin
      tick;
      checks++;
      if (dv_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL abort_discard dv %b busy %b", dv_a, busy_a); end
    end
    abort_a = 1'b1; tick; tick; abort_a = 1'b0;
    checks++;
    if (aborted_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL abort_idle aborted %b busy %b exp 0 0", aborted_a, busy_a);
    end
    start_and_run(0, 10, 1, 1'b0);
    finish_done(0, 1, 1'b0);
  endtask
`endif

  initial begin
    test_reset;
    test_no_key;
    test_single;
    test_random;
    test_long;
    test_back_to_back;
    test_rst_mid;
`ifdef AES_INV_ABORT_EN
    test_abort;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
